// File: rtl/commit_trace_buffer_pkg.sv
// Shared layout of a trace entry {pc, rd, data} and pointer sizing helpers
// for the retirement trace buffer.
package commit_trace_buffer_pkg;

  // entry layout, LSB first: data | rd | pc
  function automatic int entry_w(input int xlen, input int raddr_w);
    return 2 * xlen + raddr_w;
  endfunction

  function automatic int data_lsb();
    return 0;
  endfunction

  function automatic int rd_lsb(input int xlen);
    return xlen;
  endfunction

  function automatic int pc_lsb(input int xlen, input int raddr_w);
    return xlen + raddr_w;
  endfunction

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/commit_trace_buffer_fifo.sv
// Generic DEPTH x WIDTH circular buffer with show-ahead read, occupancy count
// and an optional overwrite-oldest mode when pushed while full.
module trace_fifo
  import commit_trace_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      overwrite,
  input  logic [WIDTH-1:0]          wdata,
  output logic [WIDTH-1:0]          rdata,
  output logic [ptr_w(DEPTH):0]     count,
  output logic                      full,
  output logic                      empty
);

  localparam int PW = ptr_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic             do_pop, blocked;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign blocked = push & full & ~do_pop;
  // memory is not reset; the empty gate keeps stale contents invisible
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (blocked) begin
      if (overwrite) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
        rd_ptr      <= rd_ptr + 1'b1;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !do_pop)      count <= count + 1'b1;
      else if (!push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Retirement trace capture beside WB: buffers retired instructions for a
// valid/ready drain and tracks cycles, retirements, halt and timeout.
module commit_trace_buffer
  import commit_trace_buffer_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int RADDR_W     = 5,
  parameter int DEPTH       = 16,
  parameter int OVERWRITE   = 0,
  parameter int HALT_REPEAT = 3,
  parameter int MAX_CYCLES  = 1000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_valid,
  input  logic                       wb_regWrite,
  input  logic [RADDR_W-1:0]         wb_rd,
  input  logic [XLEN-1:0]            wb_writeData,
  input  logic [XLEN-1:0]            wb_pc,
  output logic                       trace_valid,
  input  logic                       trace_ready,
  output logic [XLEN-1:0]            trace_pc,
  output logic [RADDR_W-1:0]         trace_rd,
  output logic [XLEN-1:0]            trace_data,
  output logic [$clog2(DEPTH):0]     fill_count,
  output logic                       overflow,
  output logic [31:0]                retire_count,
  output logic [31:0]                cycle_count,
  output logic                       halted,
  output logic                       timeout
);

  localparam int EW     = entry_w(XLEN, RADDR_W);
  localparam int RD_LSB = rd_lsb(XLEN);
  localparam int PC_LSB = pc_lsb(XLEN, RADDR_W);
  localparam int DT_LSB = data_lsb();
  localparam int RW     = $clog2(HALT_REPEAT + 1);

  logic            capture, pop, keep, fifo_full, fifo_empty;
  logic [EW-1:0]   wdata, rdata;
  logic [XLEN-1:0] last_pc;
  logic [RW-1:0]   rep, rep_next;

  assign capture = wb_valid & ~halted & ~timeout;
  assign pop     = trace_valid & trace_ready;
  assign keep    = wb_regWrite && (wb_rd != '0);
  assign wdata   = {wb_pc, keep ? wb_rd : '0, keep ? wb_writeData : '0};

  trace_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (capture),
    .pop       (pop),
    .overwrite (OVERWRITE != 0),
    .wdata     (wdata),
    .rdata     (rdata),
    .count     (fill_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign trace_valid = ~fifo_empty;
  assign trace_pc    = rdata[PC_LSB +: XLEN];
  assign trace_rd    = rdata[RD_LSB +: RADDR_W];
  assign trace_data  = rdata[DT_LSB +: XLEN];

  // rep is never above HALT_REPEAT: capture stops once halted sets
  assign rep_next = (wb_pc == last_pc) ? rep + 1'b1 : RW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow     <= 1'b0;
      retire_count <= '0;
      cycle_count  <= '0;
      halted       <= 1'b0;
      timeout      <= 1'b0;
      rep          <= '0;
      last_pc      <= '0;
    end else begin
      if (cycle_count != 32'(MAX_CYCLES)) begin
        cycle_count <= cycle_count + 1'b1;
        if (cycle_count == 32'(MAX_CYCLES - 1)) timeout <= 1'b1;
      end
      if (capture) begin
        if (retire_count != '1) retire_count <= retire_count + 1'b1;
        if (fifo_full && !pop) overflow <= 1'b1;
        rep     <= rep_next;
        last_pc <= wb_pc;
        if (rep_next == RW'(HALT_REPEAT)) halted <= 1'b1;
      end
    end
  end

endmodule
